// File: rtl/ir_nec_pkg.sv
// Shared NEC IR definitions: pulse windows (us), receiver FSM states and the
// command keymap used by every front-end that feeds the totaliser.
package ir_nec_pkg;

   localparam int unsigned LEAD_L_MIN = 8000;
   localparam int unsigned LEAD_L_MAX = 10000;
   localparam int unsigned LEAD_H_MIN = 4000;
   localparam int unsigned LEAD_H_MAX = 5000;
   localparam int unsigned RPT_H_MIN  = 2000;
   localparam int unsigned RPT_H_MAX  = 2500;
   localparam int unsigned BIT_L_MIN  = 400;
   localparam int unsigned BIT_L_MAX  = 700;
   localparam int unsigned BIT0_H_MIN = 400;
   localparam int unsigned BIT0_H_MAX = 700;
   localparam int unsigned BIT1_H_MIN = 1400;
   localparam int unsigned BIT1_H_MAX = 1900;
   localparam int unsigned STOP_L_MIN = 400;
   localparam int unsigned STOP_L_MAX = 700;

   localparam int unsigned DUR_W   = 14;
   localparam logic [DUR_W-1:0] DUR_SAT = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_LEAD_L, S_LEAD_H, S_BIT_L, S_BIT_H, S_STOP, S_CHECK, S_RPT_STOP
   } nec_state_e;

   function automatic logic in_win(input logic [DUR_W-1:0] d,
                                   input int unsigned lo, input int unsigned hi);
      logic [31:0] dv;
      dv = {{(32-DUR_W){1'b0}}, d};
      return (dv >= lo) && (dv <= hi);
   endfunction

   // Longest a state may wait for its next edge before the frame is abandoned.
   function automatic logic [31:0] state_max(input nec_state_e s);
      logic [31:0] m;
      case (s)
         S_LEAD_L:   m = LEAD_L_MAX;
         S_LEAD_H:   m = LEAD_H_MAX;
         S_BIT_L:    m = BIT_L_MAX;
         S_BIT_H:    m = BIT1_H_MAX;
         S_STOP:     m = STOP_L_MAX;
         S_RPT_STOP: m = STOP_L_MAX;
         default:    m = 32'(DUR_SAT);
      endcase
      return m;
   endfunction

   // {valid, code}: totaliser item codes, 0xFF = clear.
   function automatic logic [8:0] nec_keymap(input logic [7:0] cmd);
      logic [8:0] r;
      case (cmd)
         8'h0C:   r = {1'b1, 8'h01};
         8'h18:   r = {1'b1, 8'h02};
         8'h5E:   r = {1'b1, 8'h03};
         8'h08:   r = {1'b1, 8'h04};
         8'h45:   r = {1'b1, 8'hFF};
         default: r = 9'h000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ir_nec_rx_tick.sv
// Free-running prescaler: one-cycle tick every DIV clocks (DIV=1 ticks every clock).
module ir_us_tick #(
   parameter int unsigned DIV = 50
) (
   input  logic clock,
   input  logic clr_n,
   output logic tick_o
);
   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n)             cnt_q <= '0;
      else if (cnt_q == LAST) cnt_q <= '0;
      else                    cnt_q <= cnt_q + CW'(1);
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/ir_nec_rx.sv
// NEC IR frame receiver: measures pulse widths in us, decodes 32-bit frames and
// repeat codes, and emits one mapped item code per button press.
module ir_nec_rx
   import ir_nec_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
   input  logic       clock,
   input  logic       clr_n,
   input  logic       ir_in,
   output logic       flag,
   output logic [7:0] correspond,
   output logic [7:0] cmd_raw,
   output logic [7:0] addr,
   output logic       rpt,
   output logic       frame_err
);
   logic             tick;
   logic [1:0]       sync_q;
   logic             prev_q, rise_q, fall_q;
   logic [DUR_W-1:0] dur_q, dur_d;
   nec_state_e       state_q;
   logic [5:0]       cnt_q;
   logic [31:0]      data_q;
   logic             flag_q, rpt_q, err_q;
   logic [7:0]       corr_q, cmd_q, addr_q;
   logic             ev, ok, over;
   logic             w_data, w_b1;
   logic [8:0]       km;

   ir_us_tick #(.DIV(CLK_FREQ_HZ / 1_000_000)) u_tick (
      .clock  (clock),
      .clr_n  (clr_n),
      .tick_o (tick)
   );

   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         dur_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], ir_in};
         prev_q <= sync_q[1];
         rise_q <= sync_q[1] & ~prev_q;
         fall_q <= ~sync_q[1] & prev_q;
         dur_q  <= dur_d;
      end
   end

   always_comb begin
      dur_d = dur_q;
      if (rise_q || fall_q)              dur_d = '0;
      else if (tick && dur_q != DUR_SAT) dur_d = dur_q + DUR_W'(1);
   end

   // ev: the edge this state is waiting for; ok: that edge landed in a window.
   always_comb begin
      ev     = 1'b0;
      ok     = 1'b0;
      w_data = in_win(dur_q, LEAD_H_MIN, LEAD_H_MAX);
      w_b1   = in_win(dur_q, BIT1_H_MIN, BIT1_H_MAX);
      over   = {{(32-DUR_W){1'b0}}, dur_q} > state_max(state_q);
      km     = nec_keymap(data_q[23:16]);
      case (state_q)
         S_LEAD_L:   begin ev = rise_q; ok = in_win(dur_q, LEAD_L_MIN, LEAD_L_MAX); end
         S_LEAD_H:   begin ev = fall_q; ok = w_data || in_win(dur_q, RPT_H_MIN, RPT_H_MAX); end
         S_BIT_L:    begin ev = rise_q; ok = in_win(dur_q, BIT_L_MIN, BIT_L_MAX); end
         S_BIT_H:    begin ev = fall_q; ok = w_b1 || in_win(dur_q, BIT0_H_MIN, BIT0_H_MAX); end
         S_STOP:     begin ev = rise_q; ok = in_win(dur_q, STOP_L_MIN, STOP_L_MAX); end
         S_RPT_STOP: begin ev = rise_q; ok = in_win(dur_q, STOP_L_MIN, STOP_L_MAX); end
         default:    begin ev = 1'b0;   ok = 1'b0; end
      endcase
   end

   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         flag_q  <= 1'b0;
         rpt_q   <= 1'b0;
         err_q   <= 1'b0;
         corr_q  <= '0;
         cmd_q   <= '0;
         addr_q  <= '0;
      end else begin
         flag_q <= 1'b0;
         rpt_q  <= 1'b0;
         err_q  <= 1'b0;
         if (state_q != S_IDLE && state_q != S_CHECK && ((ev && !ok) || (!ev && over))) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE:   if (fall_q) state_q <= S_LEAD_L;
               S_LEAD_L: if (ev) state_q <= S_LEAD_H;
               S_LEAD_H: if (ev) begin
                  if (w_data) begin
                     cnt_q   <= '0;
                     state_q <= S_BIT_L;
                  end else begin
                     state_q <= S_RPT_STOP;
                  end
               end
               S_BIT_L:  if (ev) state_q <= S_BIT_H;
               S_BIT_H:  if (ev) begin
                  // LSB-first: after 32 shifts the first bit sits at data_q[0].
                  data_q  <= {w_b1, data_q[31:1]};
                  cnt_q   <= cnt_q + 6'd1;
                  state_q <= (cnt_q == 6'd31) ? S_STOP : S_BIT_L;
               end
               S_STOP:   if (ev) state_q <= S_CHECK;
               S_CHECK: begin
                  state_q <= S_IDLE;
                  if (data_q[23:16] == ~data_q[31:24]) begin
                     cmd_q  <= data_q[23:16];
                     addr_q <= data_q[7:0];
                     if (km[8]) begin
                        corr_q <= km[7:0];
                        flag_q <= 1'b1;
                     end
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               S_RPT_STOP: if (ev) begin
                  rpt_q   <= 1'b1;
                  state_q <= S_IDLE;
               end
               default:  state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign flag       = flag_q;
   assign rpt        = rpt_q;
   assign frame_err  = err_q;
   assign correspond = corr_q;
   assign cmd_raw    = cmd_q;
   assign addr       = addr_q;

endmodule

// File: tb/tb_ir_nec_rx.sv
// Randomised-timing NEC frame bench; expectations come from a frame-level model
// (checksum rule + key table) and pulse counters, not from the receiver's FSM.
`timescale 1ns/1ps
module tb_ir_nec_rx;
   logic       clock = 1'b0;
   logic       clr_n = 1'b0;
   logic       ir_in = 1'b1;
   logic       flag, rpt, frame_err;
   logic [7:0] correspond, cmd_raw, addr;

   ir_nec_rx #(.CLK_FREQ_HZ(1_000_000)) dut (
      .clock(clock), .clr_n(clr_n), .ir_in(ir_in), .flag(flag),
      .correspond(correspond), .cmd_raw(cmd_raw), .addr(addr),
      .rpt(rpt), .frame_err(frame_err)
   );

   always #5 clock = ~clock;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, seg_cyc = 0;
   int n_flag = 0, n_rpt = 0, n_err = 0, n_multi = 0;
   int last_flag_cyc = 0, last_rpt_cyc = 0, last_err_cyc = 0;
   int exp_flag = 0, exp_rpt = 0, exp_err = 0;
   logic [7:0] exp_corr = 8'h00, exp_cmd = 8'h00, exp_addr = 8'h00;

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (flag)      begin n_flag++; last_flag_cyc = cyc; end
      if (rpt)       begin n_rpt++;  last_rpt_cyc  = cyc; end
      if (frame_err) begin n_err++;  last_err_cyc  = cyc; end
      if (int'(flag) + int'(rpt) + int'(frame_err) > 1) n_multi++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Remote key table as documented for the totaliser.
   function automatic logic [8:0] ref_key(input logic [7:0] c);
      logic [7:0] keys [5] = '{8'h0C, 8'h18, 8'h5E, 8'h08, 8'h45};
      logic [7:0] vals [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
      for (int i = 0; i < 5; i++) if (keys[i] == c) return {1'b1, vals[i]};
      return 9'h000;
   endfunction

   task automatic model_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] ic);
      logic [8:0] k;
      if (ic == ~c) begin
         exp_cmd  = c;
         exp_addr = a;
         k = ref_key(c);
         if (k[8]) begin exp_corr = k[7:0]; exp_flag++; end
      end else begin
         exp_err++;
      end
   endtask

   task automatic seg(input logic lvl, input int n);
      @(negedge clock);
      ir_in   = lvl;
      seg_cyc = cyc + 1;
      repeat (n - 1) @(negedge clock);
   endtask

   task automatic send_bits(input logic [31:0] w, input int nbits);
      seg(1'b0, $urandom_range(8100, 8600));
      seg(1'b1, $urandom_range(4100, 4500));
      for (int i = 0; i < nbits; i++) begin
         seg(1'b0, $urandom_range(450, 600));
         seg(1'b1, w[i] ? $urandom_range(1450, 1700) : $urandom_range(450, 600));
      end
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] ia,
                             input logic [7:0] c, input logic [7:0] ic);
      send_bits({ic, c, ia, a}, 32);
      seg(1'b0, $urandom_range(450, 600));
      seg(1'b1, 1);
      repeat (300) @(negedge clock);
   endtask

   task automatic send_rpt();
      seg(1'b0, $urandom_range(8100, 8600));
      seg(1'b1, $urandom_range(2100, 2400));
      seg(1'b0, $urandom_range(450, 600));
      seg(1'b1, 1);
      repeat (300) @(negedge clock);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".flags"}, n_flag, exp_flag);
      chk({tag, ".rpts"}, n_rpt, exp_rpt);
      chk({tag, ".errs"}, n_err, exp_err);
      chk({tag, ".correspond"}, correspond, exp_corr);
      chk({tag, ".cmd_raw"}, cmd_raw, exp_cmd);
      chk({tag, ".addr"}, addr, exp_addr);
   endtask

   logic [7:0] a;
   int f0, rel;

   initial begin
      repeat (5) @(negedge clock);
      check_all("reset");
      chk("reset.pulses", {frame_err, rpt, flag}, 3'b000);
      clr_n = 1'b1;
      repeat (20) @(negedge clock);

      // 1: plain frame, item 2, flag 4 clocks after the stop burst ends
      send_frame(8'h00, 8'hFF, 8'h18, 8'hE7);
      model_frame(8'h00, 8'h18, 8'hE7);
      check_all("t1");
      rel = seg_cyc - 300;
      chk("t1.flag_latency", last_flag_cyc - seg_cyc, 4);

      // 2: held button: one item then three repeats, no further flags
      a = 8'($urandom);
      send_frame(a, ~a, 8'h0C, 8'hF3);
      model_frame(a, 8'h0C, 8'hF3);
      for (int r = 0; r < 3; r++) begin
         send_rpt();
         exp_rpt++;
         chk("t2.rpt_latency", last_rpt_cyc - seg_cyc, 3);
      end
      check_all("t2");

      // 3: clear key, then an unmapped command with an extended address
      a = 8'($urandom);
      send_frame(a, ~a, 8'h45, 8'hBA);
      model_frame(a, 8'h45, 8'hBA);
      check_all("t3a");
      a = 8'($urandom);
      send_frame(a, 8'($urandom), 8'h16, 8'hE9);
      model_frame(a, 8'h16, 8'hE9);
      check_all("t3b");

      // 4: bad command checksum
      a = 8'($urandom);
      send_frame(a, ~a, 8'h08, 8'hF6);
      model_frame(a, 8'h08, 8'hF6);
      check_all("t4");

      // 5: short leader, then a line stuck low past the leader limit
      seg(1'b0, 7000);
      seg(1'b1, 1);
      repeat (100) @(negedge clock);
      exp_err++;
      check_all("t5a");
      seg(1'b0, 12000);
      f0 = seg_cyc;
      seg(1'b1, 1);
      repeat (2000) @(negedge clock);
      exp_err++;
      check_all("t5b");
      chk("t5.timeout_window",
          ((last_err_cyc - f0) >= 10002 && (last_err_cyc - f0) <= 10008), 1);

      // 6: reset after bit 20, then a clean frame
      a = 8'($urandom);
      send_bits({8'hA1, 8'h5E, ~a, a}, 20);
      @(negedge clock);
      clr_n = 1'b0;
      exp_corr = 8'h00; exp_cmd = 8'h00; exp_addr = 8'h00;
      repeat (3) @(negedge clock);
      check_all("t6.reset");
      clr_n = 1'b1;
      repeat (500) @(negedge clock);
      a = 8'($urandom);
      send_frame(a, ~a, 8'h5E, 8'hA1);
      model_frame(a, 8'h5E, 8'hA1);
      check_all("t6");

      chk("exclusive_pulses", n_multi, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ir_nec_rx.md
# ir_nec_rx

Infrared remote receiver front-end for the cashier/calculator display path. Decodes NEC-format frames from a demodulated IR receiver pin, maps the command byte to the item code set consumed by the totaliser (0x01–0x04 items, 0xFF clear), and emits that code with a single-cycle `flag` pulse. A held remote button therefore produces exactly one item add. Repeat codes never re-trigger.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: system clock frequency. Must be an integer multiple of 1_000_000.
- `clock`  in  1  system clock
- `clr_n`  in  1  reset, asynchronous, active-low
- `ir_in`  in  1  raw IR receiver output. Idle high, burst = low. Asynchronous to `clock`.
- `flag`  out  1  one-cycle pulse: valid mapped frame received, `correspond` updated the same cycle
- `correspond`  out  8  mapped item code. Holds until the next valid mapped frame.
- `cmd_raw`  out  8  last checksum-valid command byte, mapped or not
- `addr`  out  8  last checksum-valid address byte
- `rpt`  out  1  one-cycle pulse on a valid repeat frame
- `frame_err`  out  1  one-cycle pulse on a timeout, out-of-window pulse, or checksum failure

## Operation
- **Input conditioning**
  - `ir_in` passes through a 2-FF synchroniser, then a registered edge detector (`fall`, `rise`).
  - A 1 µs tick divides by CLK_FREQ_HZ/1e6.
  - 14-bit `dur_us` clears on every edge and saturates at 16383.
- **Duration windows, in µs (inclusive)**
  - Leader low: 8000–10000.
  - Leader high: 4000–5000 = data frame; 2000–2500 = repeat.
  - Bit low: 400–700.
  - Bit high: 400–700 = 0; 1400–1900 = 1.
  - Stop burst low: 400–700.
- **FSM states**
  - IDLE: on `fall` → LEAD_L.
  - LEAD_L: on `rise`, if in window → LEAD_H.
  - LEAD_H: on `fall`:
    - data window → BIT_L with bit count 0;
    - repeat window → RPT_STOP.
  - BIT_L: on `rise`, if in window → BIT_H.
  - BIT_H: on `fall`, classify the bit, shift it into a 32-bit register LSB-first, and increment the count.
    - count = 32 → STOP;
    - otherwise → BIT_L.
  - STOP: on `rise`, if in window → CHECK.
  - CHECK: single cycle, always → IDLE.
  - RPT_STOP: on `rise`, if in window, pulse `rpt` and go to IDLE.
- **Frame byte order:** addr = bits[7:0], ~addr = [15:8], cmd = [23:16], ~cmd = [31:24].
- **CHECK validation:** requires cmd == ~[31:24]. The address inversion check is not required, so extended NEC is accepted.
  - On pass: latch `cmd_raw` and `addr`.
  - If cmd maps, also latch `correspond` and pulse `flag`.
- **Keymap (cmd → correspond):** 0x0C→0x01, 0x18→0x02, 0x5E→0x03, 0x08→0x04, 0x45→0xFF. Any other cmd: no `flag`, no `frame_err`.
- **Error handling:** in any non-IDLE state, an edge whose duration falls outside its window, or `dur_us` exceeding the state's upper bound, causes:
  - a `frame_err` pulse;
  - a return to IDLE.
- **No-progress timeout:** while not in IDLE and with no edge, the timeout fires in the cycle `dur_us` exceeds the bound.
  - A frame that is low and stuck therefore errors at 10001 µs.
- **Simultaneous events:** `flag`, `rpt` and `frame_err` are mutually exclusive.
- **Reset mid-frame:** all state clears immediately and no pulse is emitted for the aborted frame.

## Timing
- **Reset values:** `flag`=0, `rpt`=0, `frame_err`=0, `correspond`=0x00, `cmd_raw`=0x00, `addr`=0x00. FSM=IDLE, synchroniser=1, `dur_us`=0, tick prescaler=0.
- **Latency:** `flag` rises exactly 4 clocks after the first `clock` edge sampling `ir_in` high at the end of the stop burst, and lasts 1 cycle.
  - The 4 clocks are 2 (sync) + 1 (edge register) + 1 (CHECK).
- **Repeat latency:** `rpt` rises 3 clocks after the equivalent rising edge at the end of the repeat stop burst.
- **Duration resolution:** ±1 µs. Windows are compared on the `dur_us` value present at the edge.

## Structure
- **Shared package `ir_nec_pkg`:**
  - all window bounds as µs localparams;
  - FSM state enum;
  - keymap function `nec_keymap(cmd) → {valid, code[7:0]}`, reusable by a future UART/voice command bridge.
- **Sub-module `ir_us_tick`:** parameterised divider producing a 1-cycle tick every CLK_FREQ_HZ/1e6 clocks. Cleared by `clr_n`.
- **`ir_nec_rx` itself:** synchroniser, edge detect, duration counter, FSM, shift register and output registers.

## Test plan
All scenarios run with CLK_FREQ_HZ=1_000_000 for speed.
1. Valid frame addr=0x00, cmd=0x18 → one `flag` pulse, `correspond`=0x02, `cmd_raw`=0x18, `addr`=0x00, no `frame_err`.
2. Frame cmd=0x0C followed by three repeat frames at 108 ms spacing → exactly one `flag` (`correspond`=0x01) and three `rpt` pulses.
3. Frame cmd=0x45 → `flag` with `correspond`=0xFF. Then frame cmd=0x16 → no `flag`, `cmd_raw`=0x16, `correspond` stays 0xFF.
4. Frame cmd=0x08 with the ~cmd byte corrupted to 0xF6 → `frame_err` pulse, no `flag`, `correspond` and `cmd_raw` unchanged.
5. Leader low of 7000 µs → `frame_err` on its rise. Separately, `ir_in` held low for 12 ms → `frame_err` at 10001 µs, with IDLE reached and no second error when the line releases.
6. `clr_n` asserted after bit 20 of a valid frame → all outputs at reset values, no `flag`. The next complete frame cmd=0x5E → `flag`, `correspond`=0x03.
